// File: rtl/rv_pkg.sv
// Shared RV32I constants and fetch/decode buffer types.
package rv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD     = 7'h03;
  localparam logic [6:0] OP_MISC_MEM = 7'h0F;
  localparam logic [6:0] OP_IMM      = 7'h13;
  localparam logic [6:0] OP_AUIPC    = 7'h17;
  localparam logic [6:0] OP_STORE    = 7'h23;
  localparam logic [6:0] OP_REG      = 7'h33;
  localparam logic [6:0] OP_LUI      = 7'h37;
  localparam logic [6:0] OP_BRANCH   = 7'h63;
  localparam logic [6:0] OP_JALR     = 7'h67;
  localparam logic [6:0] OP_JAL      = 7'h6F;
  localparam logic [6:0] OP_SYSTEM   = 7'h73;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_entry;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/rv_opcode_chk.sv
// Combinational RV32I base-opcode legality check on the low 7 instruction bits.
module rv_opcode_chk
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       illegal
);

  logic known;

  always_comb begin
    known = 1'b0;
    case (opcode)
      OP_LOAD, OP_MISC_MEM, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: known = 1'b1;
      default: known = 1'b0;
    endcase
  end

  // Compressed encodings (low bits != 11) are rejected even though no listed opcode matches them.
  assign illegal = (opcode[1:0] != 2'b11) | ~known;

endmodule

// File: rtl/if_id_buf.sv
// Fetch-to-decode 2-entry skid buffer with valid/ready handshake and branch flush.
// Optional illegal-opcode flag on the head entry: define IF_ID_BUF_ILLEGAL_CHECK_EN.
//
// state     | meaning
// BUF_EMPTY | no entries, id_valid=0, NOP presented
// BUF_ONE   | one entry, fetch and decode may both transfer
// BUF_TWO   | full, if_ready=0
module if_id_buf
  import rv_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  NOP_INST = XLEN'(rv_pkg::NOP_INST)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_inst,
  output logic            if_ready,
  input  logic            brh,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_inst,
  input  logic            id_ready,
  output logic            id_illegal
);

  buf_state_t      state, state_nxt;
  logic            wr_ptr, wr_ptr_nxt;
  logic            rd_ptr, rd_ptr_nxt;
  logic [XLEN-1:0] ent_pc   [2];
  logic [XLEN-1:0] ent_inst [2];
  logic            push, pop;

  assign if_ready = (state != BUF_TWO);
  assign id_valid = (state != BUF_EMPTY);
  assign push     = if_valid & if_ready & ~brh;
  assign pop      = id_valid & id_ready & ~brh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= BUF_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (brh) begin
      state_nxt  = BUF_EMPTY;
      wr_ptr_nxt = 1'b0;
      rd_ptr_nxt = 1'b0;
    end else begin
      case (state)
        BUF_EMPTY: if (push) state_nxt = BUF_ONE;
        BUF_ONE: begin
          if (push && !pop)      state_nxt = BUF_TWO;
          else if (pop && !push) state_nxt = BUF_EMPTY;
        end
        BUF_TWO:   if (pop) state_nxt = BUF_ONE;
        default:   state_nxt = BUF_EMPTY;
      endcase
      if (push) wr_ptr_nxt = ~wr_ptr;
      if (pop)  rd_ptr_nxt = ~rd_ptr;
    end
  end

  // Slots are not cleared on flush; the zeroed pointers make stale data unreachable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        ent_pc[i]   <= '0;
        ent_inst[i] <= NOP_INST;
      end
    end else if (push) begin
      ent_pc[wr_ptr]   <= if_pc;
      ent_inst[wr_ptr] <= if_inst;
    end
  end

  assign id_pc   = id_valid ? ent_pc[rd_ptr]   : '0;
  assign id_inst = id_valid ? ent_inst[rd_ptr] : NOP_INST;

`ifdef IF_ID_BUF_ILLEGAL_CHECK_EN
  logic chk_illegal;

  rv_opcode_chk u_opcode_chk (
    .opcode  (id_inst[6:0]),
    .illegal (chk_illegal)
  );

  assign id_illegal = id_valid & chk_illegal;
`else
  assign id_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_buf.sv
// Directed self-checking bench for if_id_buf.
module tb_if_id_buf;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic            if_ready;
  logic            brh;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_inst;
  logic            id_ready;
  logic            id_illegal;

  int n_checks = 0;
  int n_errors = 0;

`ifdef IF_ID_BUF_ILLEGAL_CHECK_EN
  localparam logic ILL_ON = 1'b1;
`else
  localparam logic ILL_ON = 1'b0;
`endif

  if_id_buf dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .if_ready   (if_ready),
    .brh        (brh),
    .id_valid   (id_valid),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_ready   (id_ready),
    .id_illegal (id_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] inst);
    if_valid = v;
    if_pc    = pc;
    if_inst  = inst;
  endtask

  logic [XLEN-1:0] s_pc   [3];
  logic [XLEN-1:0] s_inst [3];
  logic [XLEN-1:0] ill_inst [3];
  logic            ill_exp  [3];

  initial begin
    rst = 1'b1; brh = 1'b0; id_ready = 1'b0;
    drive(1'b0, '0, '0);
    step();
    chk("rst_valid", 32'(id_valid), 32'd0);
    chk("rst_ready", 32'(if_ready), 32'd1);
    chk("rst_pc", id_pc, 32'h0);
    chk("rst_inst", id_inst, 32'h13);
    chk("rst_ill", 32'(id_illegal), 32'd0);
    rst = 1'b0;
    step();

    // streaming
    s_pc[0] = 32'h0; s_pc[1] = 32'h4; s_pc[2] = 32'h8;
    s_inst[0] = 32'h0050_0093; s_inst[1] = 32'h0010_8113; s_inst[2] = 32'h0020_81B3;
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, s_pc[i], s_inst[i]);
      step();
      chk("str_valid", 32'(id_valid), 32'd1);
      chk("str_ready", 32'(if_ready), 32'd1);
      chk("str_pc", id_pc, s_pc[i]);
      chk("str_inst", id_inst, s_inst[i]);
    end
    drive(1'b0, '0, '0);
    step();
    chk("str_drain", 32'(id_valid), 32'd0);

    // stall and fill
    id_ready = 1'b0;
    drive(1'b1, 32'h10, 32'h13);
    step();
    chk("fill1_pc", id_pc, 32'h10);
    chk("fill1_ready", 32'(if_ready), 32'd1);
    drive(1'b1, 32'h14, 32'h13);
    step();
    chk("fill2_ready", 32'(if_ready), 32'd0);
    chk("fill2_pc", id_pc, 32'h10);
    drive(1'b1, 32'h18, 32'h13);
    step();
    chk("held_ready", 32'(if_ready), 32'd0);
    chk("held_pc", id_pc, 32'h10);
    id_ready = 1'b1;
    step();
    chk("unst_pc0", id_pc, 32'h14);
    chk("unst_ready", 32'(if_ready), 32'd1);
    step();
    chk("unst_pc1", id_pc, 32'h18);
    drive(1'b0, '0, '0);
    step();
    chk("unst_drain", 32'(id_valid), 32'd0);

    // flush with a full buffer and a beat on the fetch side
    id_ready = 1'b0;
    drive(1'b1, 32'h30, 32'h13); step();
    drive(1'b1, 32'h34, 32'h13); step();
    chk("fl_full", 32'(if_ready), 32'd0);
    brh = 1'b1; id_ready = 1'b1;
    drive(1'b1, 32'h20, 32'h13);
    step();
    brh = 1'b0; id_ready = 1'b0;
    chk("fl_valid", 32'(id_valid), 32'd0);
    chk("fl_ready", 32'(if_ready), 32'd1);
    drive(1'b1, 32'h100, 32'h13);
    step();
    drive(1'b0, '0, '0);
    chk("fl_new_pc", id_pc, 32'h100);
    step();
    chk("fl_alone_ready", 32'(if_ready), 32'd1);
    chk("fl_alone_pc", id_pc, 32'h100);
    id_ready = 1'b1;
    step();
    chk("fl_new_drain", 32'(id_valid), 32'd0);
    // flush on an empty buffer must also block the push
    brh = 1'b1;
    drive(1'b1, 32'h200, 32'h13);
    step();
    brh = 1'b0;
    drive(1'b0, '0, '0);
    chk("fl_empty_push", 32'(id_valid), 32'd0);

    // wrap-around at count=1
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h40 + 32'(4 * i), 32'h13);
      step();
      chk("wrap_pc", id_pc, 32'h40 + 32'(4 * i));
      chk("wrap_ready", 32'(if_ready), 32'd1);
    end
    drive(1'b0, '0, '0);
    step();
    chk("wrap_drain", 32'(id_valid), 32'd0);

    // illegal-opcode flag
    ill_inst[0] = 32'hFFFF_FFFC; ill_exp[0] = ILL_ON;
    ill_inst[1] = 32'h0000_007F; ill_exp[1] = ILL_ON;
    ill_inst[2] = 32'h0000_0013; ill_exp[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h80 + 32'(4 * i), ill_inst[i]);
      step();
      chk("ill_inst", id_inst, ill_inst[i]);
      chk("ill_flag", 32'(id_illegal), 32'(ill_exp[i]));
    end
    drive(1'b0, '0, '0);
    step();

    // asynchronous reset with a full buffer
    id_ready = 1'b0;
    drive(1'b1, 32'h60, 32'h0000_0033); step();
    drive(1'b1, 32'h64, 32'h0000_0033); step();
    drive(1'b0, '0, '0);
    chk("ar_full", 32'(if_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(id_valid), 32'd0);
    chk("ar_ready", 32'(if_ready), 32'd1);
    chk("ar_inst", id_inst, 32'h13);
    chk("ar_pc", id_pc, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk("ar_hold", 32'(id_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
